// File: rtl/input_debounce_pair_pkg.sv
// Shared constants for the two-channel switch debouncer: FSM state encodings and default debounce length.
package db_pkg;

  localparam logic [1:0] S_LO     = 2'b00;
  localparam logic [1:0] S_CHK_HI = 2'b01;
  localparam logic [1:0] S_HI     = 2'b11;
  localparam logic [1:0] S_CHK_LO = 2'b10;

  localparam int DB_CYCLES_DEFAULT = 1000;

  typedef enum logic [1:0] {
    ST_LO     = S_LO,
    ST_CHK_HI = S_CHK_HI,
    ST_HI     = S_HI,
    ST_CHK_LO = S_CHK_LO
  } db_state_t;

endpackage

// File: rtl/input_debounce_pair_if.sv
// Signal bundle of the debouncer: raw switch levels in, clean levels, edge pulses and FSM state out.
interface input_debounce_pair_if;
  // Plain level interface: no valid/ready handshake; every output is a registered level
  // that is meaningful on every cycle outside reset.
  logic       a_raw_i;
  logic       b_raw_i;
  logic       a_o;
  logic       b_o;
  logic       a_rise_o;
  logic       a_fall_o;
  logic       b_rise_o;
  logic       b_fall_o;
  logic [1:0] a_state_o;
  logic [1:0] b_state_o;

  modport master (
    output a_raw_i, b_raw_i,
    input  a_o, b_o, a_rise_o, a_fall_o, b_rise_o, b_fall_o, a_state_o, b_state_o
  );

  modport slave (
    input  a_raw_i, b_raw_i,
    output a_o, b_o, a_rise_o, a_fall_o, b_rise_o, b_fall_o, a_state_o, b_state_o
  );
endinterface

// File: rtl/input_debounce_pair_chan.sv
// One debounce channel: 2-flop synchronizer feeding a counter-qualified 4-state FSM.
// Optional registered edge pulses when DEBOUNCE_EDGE_PULSE_EN is defined; otherwise tied to 0.
module debounce_chan
  import db_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_raw,
  output logic       o_level,
  output logic       o_rise,
  output logic       o_fall,
  output logic [1:0] o_state
);

  localparam int CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  db_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             w_s;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic r_rise;
  logic r_fall;
`endif

  assign w_s = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= ST_LO;
      r_cnt   <= '0;
      r_out   <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`endif
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`endif
      case (r_state)
        ST_LO: begin
          if (w_s) begin
            r_state <= ST_CHK_HI;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_CHK_HI: begin
          // Any return to the old level discards all progress.
          if (!w_s) begin
            r_state <= ST_LO;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state <= ST_HI;
            r_out   <= 1'b1;
            r_cnt   <= '0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            r_rise  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HI: begin
          if (!w_s) begin
            r_state <= ST_CHK_LO;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_CHK_LO: begin
          if (w_s) begin
            r_state <= ST_HI;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state <= ST_LO;
            r_out   <= 1'b0;
            r_cnt   <= '0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            r_fall  <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_LO;
          r_cnt   <= '0;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

  assign o_level = r_out;
  assign o_state = r_state;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  assign o_rise = r_rise;
  assign o_fall = r_fall;
`else
  assign o_rise = 1'b0;
  assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/input_debounce_pair.sv
// Two independent switch debouncers (A and B) feeding a downstream AND stage; wiring only.
// Edge pulses are enabled by defining DEBOUNCE_EDGE_PULSE_EN.
module input_debounce_pair
  import db_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  input_debounce_pair_if.slave bus
);

  debounce_chan #(.DB_CYCLES(DB_CYCLES)) u_chan_a (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (bus.a_raw_i),
    .o_level (bus.a_o),
    .o_rise  (bus.a_rise_o),
    .o_fall  (bus.a_fall_o),
    .o_state (bus.a_state_o)
  );

  debounce_chan #(.DB_CYCLES(DB_CYCLES)) u_chan_b (
    .clk     (clk),
    .rst     (rst),
    .i_raw   (bus.b_raw_i),
    .o_level (bus.b_o),
    .o_rise  (bus.b_rise_o),
    .o_fall  (bus.b_fall_o),
    .o_state (bus.b_state_o)
  );

endmodule

// File: tb/tb_input_debounce_pair.sv
// Bench for input_debounce_pair with DB_CYCLES=4: run-length reference model plus directed scenarios.
module tb_input_debounce_pair;
  localparam int DB = 4;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit PULSE_ON = 1'b1;
`else
  localparam bit PULSE_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_debounce_pair_if bus ();

  input_debounce_pair #(.DB_CYCLES(DB)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FSM sees the raw level two edges late; a channel flips once it has
  // seen DB consecutive samples that differ from its current output.
  bit         m_dly0 [2];
  bit         m_dly1 [2];
  bit         m_lvl  [2];
  int         m_run  [2];
  bit         m_rise [2];
  bit         m_fall [2];
  logic [5:0] exp_q[$];

  always @(posedge clk) begin
    bit raw [2];
    bit s;
    logic [5:0] exp_v;
    raw[0] = bus.a_raw_i;
    raw[1] = bus.b_raw_i;
    for (int ch = 0; ch < 2; ch++) begin
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
      if (rst) begin
        m_dly0[ch] = 1'b0;
        m_dly1[ch] = 1'b0;
        m_lvl[ch]  = 1'b0;
        m_run[ch]  = 0;
      end else begin
        s = m_dly1[ch];
        m_dly1[ch] = m_dly0[ch];
        m_dly0[ch] = raw[ch];
        m_run[ch] = (s != m_lvl[ch]) ? m_run[ch] + 1 : 0;
        if (m_run[ch] == DB) begin
          m_lvl[ch]  = ~m_lvl[ch];
          m_run[ch]  = 0;
          m_rise[ch] = PULSE_ON & m_lvl[ch];
          m_fall[ch] = PULSE_ON & ~m_lvl[ch];
        end
      end
    end
    exp_q.push_back({m_lvl[0], m_lvl[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1]});
    #1;
    exp_v = exp_q.pop_front();
    check("model_outs", {26'd0, bus.a_o, bus.b_o, bus.a_rise_o, bus.a_fall_o,
                         bus.b_rise_o, bus.b_fall_o}, {26'd0, exp_v});
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit a, input bit b);
    @(negedge clk);
    bus.a_raw_i = a;
    bus.b_raw_i = b;
  endtask

  task automatic settle(input bit a, input bit b);
    drive(a, b);
    repeat (10) step();
  endtask

  initial begin
    int fall_cnt;
    bus.a_raw_i = 1'b0;
    bus.b_raw_i = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("reset_a_o", bus.a_o, 1'b0);
    check("reset_b_o", bus.b_o, 1'b0);
    check("reset_a_state", bus.a_state_o, 2'b00);
    check("reset_b_state", bus.b_state_o, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // 1: asynchronous reset while both channels are high
    settle(1'b1, 1'b1);
    check("t1_pre_a", bus.a_o, 1'b1);
    check("t1_pre_b", bus.b_o, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t1_async_outs", {bus.a_o, bus.b_o, bus.a_rise_o, bus.a_fall_o, bus.b_rise_o, bus.b_fall_o}, 6'd0);
    check("t1_async_state", {bus.a_state_o, bus.b_state_o}, 4'b0000);
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t1_hold_low", {bus.a_o, bus.b_o}, 2'b00);
    end
    step();
    check("t1_requal", {bus.a_o, bus.b_o}, 2'b11);

    // 2: clean rise on A
    settle(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t2_wait_a", bus.a_o, 1'b0);
    end
    step();
    check("t2_rise_a", bus.a_o, 1'b1);
    check("t2_rise_pulse", bus.a_rise_o, PULSE_ON);
    step();
    check("t2_pulse_end", bus.a_rise_o, 1'b0);

    // 3: bounce on A, then a clean hold
    settle(1'b0, 1'b1);
    drive(1'b1, 1'b1); step(); check("t3_bounce", bus.a_o, 1'b0);
    drive(1'b0, 1'b1); step(); check("t3_bounce", bus.a_o, 1'b0);
    drive(1'b1, 1'b1); step(); check("t3_bounce", bus.a_o, 1'b0);
    drive(1'b0, 1'b1); step(); check("t3_bounce", bus.a_o, 1'b0);
    drive(1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t3_wait_a", bus.a_o, 1'b0);
    end
    step();
    check("t3_rise_a", bus.a_o, 1'b1);

    // 4: three-cycle glitch low on B
    fall_cnt = 0;
    drive(1'b1, 1'b0);
    step();
    if (bus.b_fall_o) fall_cnt++;
    drive(1'b1, 1'b0);
    step();
    if (bus.b_fall_o) fall_cnt++;
    drive(1'b1, 1'b0);
    step();
    if (bus.b_fall_o) fall_cnt++;
    drive(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.b_fall_o) fall_cnt++;
      check("t4_b_held", bus.b_o, 1'b1);
    end
    check("t4_no_fall", fall_cnt, 0);

    // 5: simultaneous rise, downstream AND
    settle(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t5_and_low", bus.a_o & bus.b_o, 1'b0);
    end
    step();
    check("t5_both", {bus.a_o, bus.b_o}, 2'b11);
    check("t5_and_high", bus.a_o & bus.b_o, 1'b1);

    // 6: reset in the middle of qualification
    settle(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    repeat (4) step();
    check("t6_mid_state", bus.a_state_o, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_outs", {bus.a_o, bus.a_rise_o, bus.a_fall_o}, 3'b000);
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t6_wait_a", bus.a_o, 1'b0);
    end
    step();
    check("t6_requal_a", bus.a_o, 1'b1);
    check("t6_requal_pulse", bus.a_rise_o, PULSE_ON);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
